final_project_otg_hpi_int: RTL and testbench
============================================

// Module: final_project_otg_hpi_int
// PURPOSE
// - Avalon-MM slave input PIO: samples the external OTG HPI interrupt line(s) into the clk domain.
// - Detects programmable edges and latches them in a sticky edge-capture register.
// - Raises a maskable level interrupt toward the Nios II.
// - Input-direction counterpart of the output-only HPI control PIOs on the same slave bus.
// PARAMETERS
// - WIDTH         1  number of in_port bits (1..32)
// - EDGE_TYPE     0  0 = rising, 1 = falling, 2 = any edge
// - SYNC_STAGES   2  flops in input synchronizer (2..4)
// - FILTER_CYCLES 4  stable cycles required by glitch filter (2..16; used only with macro)
// PORTS
// - clk         in   1      system clock
// - reset       in   1      asynchronous, active-high reset
// - address     in   2      register select: 0 data, 1 direction (RO 0), 2 irqmask, 3 edgecapture
// - chipselect  in   1      slave select
// - write_n     in   1      active-low write strobe
// - writedata   in   32     write data; bits [WIDTH-1:0] used
// - in_port     in   WIDTH  asynchronous external HPI INT line(s)
// - readdata    out  32     registered read data, zero-extended above WIDTH
// - irq         out  1      level interrupt: |(edge_capture & irq_mask)
// BEHAVIOUR
// - Reset: sync chain, filtered value, prev value, irq_mask, edge_capture, readdata all 0; irq 0.
// - Synchronizer: in_port passes through SYNC_STAGES flops -> s_in.
// - Without filter: s_in is the clean value c_in.
// - Edge detect: prev <= c_in every cycle.
//   - rise = c_in & ~prev; fall = ~c_in & prev; edge selected per EDGE_TYPE.
// - edge_capture[i] sets on the cycle after c_in[i] changes.
//   - Stays set until cleared by a write-1 to address 3 (chipselect & ~write_n).
//   - Written 0 bits are unaffected.
//   - Set and clear of the same bit in one cycle: set wins (edge never lost).
// - irq_mask: written from writedata[WIDTH-1:0] at address 2.
// - irq: combinational from registers; asserts the same cycle edge_capture & irq_mask != 0.
//   - Mask write with pending capture asserts irq the cycle after the write.
// - Writes to address 0 or 1 are ignored.
// - readdata: registered every clk from the address mux, independent of chipselect; read latency 1.
//   - addr 0 -> c_in; addr 1 -> 0; addr 2 -> irq_mask; addr 3 -> edge_capture.
//   - Bits [31:WIDTH] always 0.
// - Latency, in_port change -> visible at addr 0: SYNC_STAGES+1 cycles (+FILTER_CYCLES with filter).
// - Reset asserted mid-operation clears all state immediately.
//   - No edge is reported on release, because prev and c_in both restart at 0.
//   - A line that is high at release produces a rising edge once it has propagated.
// CONFIGURATION
// - Macro OTG_HPI_INT_GLITCH_FILTER_EN.
// - Defined: per-bit counter; c_in[i] updates only after s_in[i] differs from c_in[i] for
//   FILTER_CYCLES consecutive cycles. The counter resets to 0 whenever they match.
// - Undefined: c_in = s_in; no counter logic instantiated; FILTER_CYCLES ignored.
// STRUCTURE
// - Package final_project_pio_pkg holds:
//   - register offsets ADDR_DATA/ADDR_DIR/ADDR_IRQMASK/ADDR_EDGECAP;
//   - EDGE_RISE/EDGE_FALL/EDGE_ANY constants;
//   - DATA_W = 32.
// - Sub-module final_project_pio_sync_filter: synchronizer plus optional glitch filter, one per bit.
// - Top holds edge detect, registers, read mux and irq.
// TESTING
// - Reset: assert reset mid-stream with in_port=1 -> readdata, irq, mask, capture read 0.
//   - After release, data reads 1 only after SYNC_STAGES+1 cycles.
// - Rising edge, EDGE_TYPE=0, mask=1: in_port 0->1 -> edgecapture=1, irq=1 at the expected cycle.
//   - Write 1 to addr 3 -> capture 0, irq 0 next cycle.
// - Mask: edge with irq_mask=0 -> capture=1, irq=0; then write mask=1 -> irq=1 the cycle after.
// - Collision: W1C to addr 3 in the exact cycle a new edge sets bit 0 -> capture stays 1.
// - Glitch filter defined, FILTER_CYCLES=4: 3-cycle pulse -> no data change, no capture.
//   - 5-cycle pulse -> capture=1.
// - Readback, WIDTH=1: write 0xFFFFFFFF to addr 2 -> reads 0x00000001.
//   - Addr 1 reads 0; writes to addr 0 have no effect.

Source files
------------

// File: rtl/final_project_pio_pkg.sv
// Shared definitions for the OTG HPI input PIO: register map, edge modes, bus width.
// No logic of its own; no latency or backpressure.
// The edge selector helper works on one bit.
package final_project_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Decoded slave write strobes for the two writable registers.
    typedef struct packed {
        logic mask_wr;
        logic clr_wr;
    } bus_wr_t;

    function automatic logic edge_sel(input int edge_type, input logic cur, input logic prev);
        case (edge_type)
            EDGE_FALL: return ~cur & prev;
            EDGE_ANY:  return cur ^ prev;
            default:   return cur & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/final_project_pio_sync_filter.sv
// Per-bit synchronizer plus optional glitch filter (OTG_HPI_INT_GLITCH_FILTER_EN).
// Latency: SYNC_STAGES cycles, plus FILTER_CYCLES when the filter is built.
// No backpressure: samples every cycle.
module final_project_pio_sync_filter #(
    parameter int WIDTH         = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] c_in
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_in = sync_q[SYNC_STAGES-1];

`ifdef OTG_HPI_INT_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // The counter tracks how long s_in has disagreed with the accepted value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s_in[i] == filt_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt_q[i] <= s_in[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign c_in = filt_q;
`else
    logic unused_filter_cycles;

    assign unused_filter_cycles = (FILTER_CYCLES > 0);
    assign c_in = s_in;
`endif

endmodule

// File: rtl/final_project_otg_hpi_int.sv
// Avalon-MM input PIO for the OTG HPI interrupt: edge capture, irq mask, maskable level irq.
// Latency: read data 1 cycle; in_port to data SYNC_STAGES+1 (+FILTER_CYCLES with OTG_HPI_INT_GLITCH_FILTER_EN).
// No backpressure: slave accepts every access with fixed latency.
module final_project_otg_hpi_int
    import final_project_pio_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int EDGE_TYPE     = 0,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic [WIDTH-1:0]  c_in;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_capture;
    logic [WIDTH-1:0]  edge_det;
    logic [WIDTH-1:0]  clr_bits;
    logic [DATA_W-1:0] rd_mux;
    bus_wr_t           wr;

    final_project_pio_sync_filter #(
        .WIDTH         (WIDTH),
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sync_filter (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .c_in    (c_in)
    );

    always_comb begin
        wr.mask_wr = chipselect & ~write_n & (address == ADDR_IRQMASK);
        wr.clr_wr  = chipselect & ~write_n & (address == ADDR_EDGECAP);
    end

    always_comb begin
        edge_det = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_det[i] = edge_sel(EDGE_TYPE, c_in[i], prev[i]);
        end
    end

    assign clr_bits = wr.clr_wr ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = c_in;
            ADDR_DIR:     rd_mux = '0;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
            default:      rd_mux = '0;
        endcase
    end

    // OR-ing edge_det after the clear makes a coincident new edge win over W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            prev         <= c_in;
            edge_capture <= (edge_capture & ~clr_bits) | edge_det;
            readdata     <= rd_mux;
            if (wr.mask_wr) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

    generate
        if (WIDTH < DATA_W) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[DATA_W-1:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_final_project_otg_hpi_int.sv
// Bench for final_project_otg_hpi_int (default parameters), with a delay-line reference model.
module tb_final_project_otg_hpi_int;

    localparam int S    = 2;
    localparam int F    = 4;
    localparam int EDGE = 0;
`ifdef OTG_HPI_INT_GLITCH_FILTER_EN
    localparam int LAT = S + 1 + F;
`else
    localparam int LAT = S + 1;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [0:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    final_project_otg_hpi_int #(
        .WIDTH         (1),
        .EDGE_TYPE     (EDGE),
        .SYNC_STAGES   (S),
        .FILTER_CYCLES (F)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in_port delay line, optional run-length filter, register file.
    bit          mq[$];
    bit          shq[$];
    bit          c_cur, c_old, mask_m, cap_m;
    logic [31:0] rd_m;

    function automatic void mdl_reset();
        mq.delete();
        shq.delete();
        for (int i = 0; i < S; i++) mq.push_back(1'b0);
        for (int i = 0; i < F; i++) shq.push_back(1'b0);
        c_cur  = 1'b0;
        c_old  = 1'b0;
        mask_m = 1'b0;
        cap_m  = 1'b0;
        rd_m   = '0;
    endfunction

    function automatic void mdl_edge();
        bit wr, ed, s_new, c_new, same;
        wr = chipselect && !write_n;
        case (address)
            2'd0:    rd_m = {31'b0, c_cur};
            2'd2:    rd_m = {31'b0, mask_m};
            2'd3:    rd_m = {31'b0, cap_m};
            default: rd_m = '0;
        endcase
        case (EDGE)
            1:       ed = !c_cur && c_old;
            2:       ed = c_cur != c_old;
            default: ed = c_cur && !c_old;
        endcase
        if (wr && address == 2'd3 && writedata[0]) cap_m = 1'b0;
        cap_m = cap_m | ed;
        if (wr && address == 2'd2) mask_m = writedata[0];
        mq.push_back(in_port[0]);
        void'(mq.pop_front());
        s_new = mq[0];
`ifdef OTG_HPI_INT_GLITCH_FILTER_EN
        same = 1'b1;
        foreach (shq[i]) if (shq[i] != shq[0]) same = 1'b0;
        c_new = (same && shq[0] != c_cur) ? shq[0] : c_cur;
        shq.push_back(s_new);
        void'(shq.pop_front());
`else
        same  = 1'b1;
        c_new = s_new & same;
`endif
        c_old = c_cur;
        c_cur = c_new;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) mdl_edge();
        #1;
        chk("mdl_readdata", readdata, rd_m);
        chk("mdl_irq", 32'(irq), 32'(mask_m & cap_m));
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        step();
        idle();
    endtask

    typedef struct {
        logic [1:0]  addr;
        bit          cs;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;

    vec_t tbl[12];
    int   hold;

    initial begin
        // Register access table: exp_rd is the value held before that cycle's write.
        tbl[0]  = '{2'd2, 1, 1, 32'hFFFF_FFFF, 32'h0, 0};
        tbl[1]  = '{2'd2, 0, 0, 32'h0,         32'h1, 0};
        tbl[2]  = '{2'd1, 1, 1, 32'hFFFF_FFFF, 32'h0, 0};
        tbl[3]  = '{2'd1, 0, 0, 32'h0,         32'h0, 0};
        tbl[4]  = '{2'd0, 1, 1, 32'hFFFF_FFFF, 32'h0, 0};
        tbl[5]  = '{2'd0, 0, 0, 32'h0,         32'h0, 0};
        tbl[6]  = '{2'd3, 1, 1, 32'h1,         32'h0, 0};
        tbl[7]  = '{2'd3, 0, 0, 32'h0,         32'h0, 0};
        tbl[8]  = '{2'd2, 1, 1, 32'h0,         32'h1, 0};
        tbl[9]  = '{2'd2, 0, 0, 32'h0,         32'h0, 0};
        tbl[10] = '{2'd2, 1, 1, 32'h1,         32'h0, 0};
        tbl[11] = '{2'd2, 1, 0, 32'h0,         32'h1, 0};

        reset   = 1'b1;
        in_port = '0;
        address = '0;
        idle();
        mdl_reset();
        #1;
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        repeat (3) step();
        reset = 1'b0;
        repeat (LAT + 2) step();

        for (int i = 0; i < 12; i++) begin
            address    = tbl[i].addr;
            chipselect = tbl[i].cs;
            write_n    = !tbl[i].wr;
            writedata  = tbl[i].wdata;
            step();
            chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end
        idle();
        address = 2'd0;

        // Rising edge with mask=1, then W1C.
        in_port = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k == LAT - 1) chk("rise_irq_early", 32'(irq), 32'h0);
            if (k == LAT)     chk("rise_irq", 32'(irq), 32'h1);
        end
        address = 2'd3;
        step();
        chk("rise_cap_rd", readdata, 32'h1);
        bus_wr(2'd3, 32'h1);
        chk("w1c_irq", 32'(irq), 32'h0);
        step();
        chk("w1c_cap_rd", readdata, 32'h0);

        // Edge with mask=0, then unmask.
        in_port = 1'b0;
        repeat (LAT + 2) step();
        bus_wr(2'd2, 32'h0);
        in_port = 1'b1;
        address = 2'd3;
        repeat (LAT + 1) step();
        chk("masked_cap_rd", readdata, 32'h1);
        chk("masked_irq", 32'(irq), 32'h0);
        bus_wr(2'd2, 32'h1);
        chk("unmask_irq", 32'(irq), 32'h1);

        // W1C in the same cycle a new edge sets the bit.
        in_port = 1'b0;
        repeat (LAT + 2) step();
        bus_wr(2'd3, 32'h1);
        chk("coll_pre_irq", 32'(irq), 32'h0);
        in_port = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            if (k == LAT) begin
                address    = 2'd3;
                chipselect = 1'b1;
                write_n    = 1'b0;
                writedata  = 32'h1;
            end
            step();
            idle();
        end
        chk("coll_irq", 32'(irq), 32'h1);
        address = 2'd3;
        step();
        chk("coll_cap_rd", readdata, 32'h1);

        // Mid-cycle reset with the line held high.
        #4;
        reset = 1'b1;
        mdl_reset();
        #1;
        chk("midrst_readdata", readdata, 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        repeat (2) step();
        reset = 1'b0;
        address = 2'd3;
        step();
        chk("rst_cap_rd", readdata, 32'h0);
        address = 2'd0;
        for (int k = 2; k <= LAT; k++) begin
            step();
            chk($sformatf("rst_data_k%0d", k), readdata, (k == LAT) ? 32'h1 : 32'h0);
            chk($sformatf("rst_irq_k%0d", k), 32'(irq), 32'h0);
        end
        address = 2'd2;
        step();
        chk("rst_mask_rd", readdata, 32'h0);
        address = 2'd3;
        step();
        chk("rst_release_edge", readdata, 32'h1);

`ifdef OTG_HPI_INT_GLITCH_FILTER_EN
        in_port = 1'b0;
        repeat (LAT + 2) step();
        bus_wr(2'd2, 32'h1);
        bus_wr(2'd3, 32'h1);
        address = 2'd0;
        in_port = 1'b1;
        repeat (3) step();
        in_port = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            step();
            chk("glitch3_data", readdata, 32'h0);
        end
        address = 2'd3;
        step();
        chk("glitch3_cap", readdata, 32'h0);
        in_port = 1'b1;
        repeat (5) step();
        in_port = 1'b0;
        repeat (LAT + 4) step();
        chk("pulse5_cap", readdata, 32'h1);
        chk("pulse5_irq", 32'(irq), 32'h1);
`endif

        // Randomized traffic against the model.
        #4;
        reset = 1'b1;
        mdl_reset();
        repeat (2) step();
        reset = 1'b0;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                in_port = 1'($urandom_range(0, 1));
                hold    = $urandom_range(1, 8);
            end
            hold--;
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
